rv32i_retire_monitor: RTL and testbench

//  Synthesizable successor to the bench-side retire monitor. Sits beside rv32i_core and taps the writeback stage.

---
 rtl/rv32i_retire_monitor.sv | 144 ++++++++++++++
 tb/tb_rv32i_retire_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_retire_monitor.sv
// Retire monitor for rv32i_core: traces writeback commits into a show-ahead FIFO,
// detects test end (exception mask or watchdog) and grades it with the riscv-tests exit convention.
module rv32i_retire_monitor #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [2:0]  HALT_MASK      = 3'b011,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter bit          TRACE_ALL      = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_retire_valid,
  input  logic [31:0]  i_retire_pc,
  input  logic         i_rd_wr,
  input  logic [4:0]   i_rd_addr,
  input  logic [31:0]  i_rd_data,
  input  logic         i_mem_we,
  input  logic [31:0]  i_mem_addr,
  input  logic [31:0]  i_mem_data,
  input  logic [3:0]   i_mem_sel,
  input  logic         i_exc_ecall,
  input  logic         i_exc_ebreak,
  input  logic         i_exc_illegal,
  input  logic [31:0]  i_a0,
  input  logic [31:0]  i_a7,
  output logic         o_trace_valid,
  input  logic         i_trace_ready,
  output logic [138:0] o_trace_data,
  output logic         o_overflow,
  output logic [15:0]  o_drop_count,
  output logic [31:0]  o_retire_count,
  output logic [31:0]  o_cycle_count,
  output logic [2:0]   o_status,
  output logic [30:0]  o_exit_code,
  output logic         o_done
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned RW       = 139;
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] EXIT_A7  = 32'h0000_005d;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_UNKNOWN = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_t;

  state_t        state, state_nx;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, occ;
  logic [RW-1:0] rec;
  logic          in_run, empty, full, push, pop, accept, halt_evt, timeout;
  status_t       halt_status;

  assign in_run = (state == S_RUN);
  assign occ    = wr_ptr - rd_ptr;
  assign empty  = (occ == '0);
  assign full   = (occ == DEPTH_V);

  assign rec = {i_retire_pc, i_rd_wr, i_rd_addr, i_rd_data,
                i_mem_we, i_mem_sel, i_mem_addr, i_mem_data};

  assign halt_evt = in_run & i_retire_valid &
                    (|(HALT_MASK & {i_exc_illegal, i_exc_ebreak, i_exc_ecall}));
  assign timeout  = in_run & WDOG_EN & (o_cycle_count == TMO_LAST) & ~halt_evt;

  assign push   = in_run & i_retire_valid &
                  (TRACE_ALL | (i_rd_wr & (|i_rd_addr)) | i_mem_we);
  assign pop    = ~empty & i_trace_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept = push & (~full | pop);

  assign o_trace_valid = ~empty;
  assign o_trace_data  = mem[rd_ptr[AW-1:0]];
  assign o_done        = (state == S_DONE);

  always_comb begin
    halt_status = ST_FAIL;
    if (i_a7 != EXIT_A7)
      halt_status = ST_UNKNOWN;
    else if (i_a0 == '0)
      halt_status = ST_PASS;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN:   if (halt_evt | timeout) state_nx = S_DRAIN;
      // Nothing is pushed outside RUN, so empty-after-this-cycle is occ minus pop.
      S_DRAIN: if (empty | ((occ == PTR_ONE) & pop)) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (accept)
      mem[wr_ptr[AW-1:0]] <= rec;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_RUN;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_overflow     <= 1'b0;
      o_drop_count   <= '0;
      o_retire_count <= '0;
      o_cycle_count  <= '0;
      o_status       <= ST_RUN;
      o_exit_code    <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push & ~accept) begin
        o_overflow <= 1'b1;
        if (o_drop_count != '1)
          o_drop_count <= o_drop_count + 16'd1;
      end
      if (in_run) begin
        o_cycle_count <= o_cycle_count + 32'd1;
        if (i_retire_valid)
          o_retire_count <= o_retire_count + 32'd1;
      end
      if (halt_evt) begin
        o_status    <= halt_status;
        o_exit_code <= i_a0[31:1];
      end else if (timeout) begin
        o_status    <= ST_TIMEOUT;
        o_exit_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_retire_monitor.sv
// Scoreboard bench for rv32i_retire_monitor: a queue-based reference model predicts trace records,
// counters and grading for two parameterisations driven by the same retire stream.
module tb_rv32i_retire_monitor;

  localparam int unsigned DEPTH   = 16;
  localparam bit          TRACE_P = 1'b0;
  localparam logic [2:0]  MASK_A  = 3'b011;
  localparam logic [2:0]  MASK_B  = 3'b001;
  localparam int unsigned TMO_A   = 0;
  localparam int unsigned TMO_B   = 50;

  logic        clk;
  logic        rst;
  logic        rv;
  logic [31:0] pc;
  logic        rd_wr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_sel;
  logic        ecall, ebreak, illegal;
  logic [31:0] a0, a7;
  logic        ready;

  logic         a_valid, a_ovf, a_done;
  logic [138:0] a_data;
  logic [15:0]  a_drop;
  logic [31:0]  a_ret, a_cyc;
  logic [2:0]   a_status;
  logic [30:0]  a_exit;

  logic         b_valid, b_ovf, b_done;
  logic [138:0] b_data;
  logic [15:0]  b_drop;
  logic [31:0]  b_ret, b_cyc;
  logic [2:0]   b_status;
  logic [30:0]  b_exit;

  rv32i_retire_monitor #(
    .FIFO_DEPTH(DEPTH), .HALT_MASK(MASK_A), .TIMEOUT_CYCLES(TMO_A), .TRACE_ALL(TRACE_P)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_retire_valid(rv), .i_retire_pc(pc),
    .i_rd_wr(rd_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_sel(mem_sel),
    .i_exc_ecall(ecall), .i_exc_ebreak(ebreak), .i_exc_illegal(illegal),
    .i_a0(a0), .i_a7(a7),
    .o_trace_valid(a_valid), .i_trace_ready(ready), .o_trace_data(a_data),
    .o_overflow(a_ovf), .o_drop_count(a_drop), .o_retire_count(a_ret), .o_cycle_count(a_cyc),
    .o_status(a_status), .o_exit_code(a_exit), .o_done(a_done)
  );

  rv32i_retire_monitor #(
    .FIFO_DEPTH(DEPTH), .HALT_MASK(MASK_B), .TIMEOUT_CYCLES(TMO_B), .TRACE_ALL(TRACE_P)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_retire_valid(rv), .i_retire_pc(pc),
    .i_rd_wr(rd_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_sel(mem_sel),
    .i_exc_ecall(ecall), .i_exc_ebreak(ebreak), .i_exc_illegal(illegal),
    .i_a0(a0), .i_a7(a7),
    .o_trace_valid(b_valid), .i_trace_ready(ready), .o_trace_data(b_data),
    .o_overflow(b_ovf), .o_drop_count(b_drop), .o_retire_count(b_ret), .o_cycle_count(b_cyc),
    .o_status(b_status), .o_exit_code(b_exit), .o_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: test phase (0 running, 1 draining, 2 done), occupancy and counters.
  typedef struct {
    int          ph;
    int          occ;
    logic [31:0] ret;
    logic [31:0] cyc;
    int          status;
    logic [30:0] exit_code;
    bit          ovf;
    int          drop;
  } mdl_t;

  mdl_t         ma, mb;
  logic [138:0] sb[$];
  logic [138:0] exp_rec;
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic mdl_t mstep(input mdl_t m, input logic [2:0] mask, input int unsigned tmo,
                                 output bit accepted);
    mdl_t n;
    bit pop, push, halt, tmo_hit;
    n = m;
    accepted = 1'b0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    pop = (m.occ > 0) && ready;
    push = 1'b0;
    halt = 1'b0;
    tmo_hit = 1'b0;
    if (m.ph == 0) begin
      n.cyc = m.cyc + 32'd1;
      if (rv) begin
        n.ret = m.ret + 32'd1;
        halt = (ecall && mask[0]) || (ebreak && mask[1]) || (illegal && mask[2]);
        push = TRACE_P || (rd_wr && rd_addr != 5'd0) || mem_we;
      end
      tmo_hit = (tmo != 0) && (m.cyc == 32'(tmo - 1)) && !halt;
    end
    accepted = push && ((m.occ < int'(DEPTH)) || pop);
    if (push && !accepted) begin
      n.ovf = 1'b1;
      if (m.drop < 65535) n.drop = m.drop + 1;
    end
    n.occ = m.occ + (accepted ? 1 : 0) - (pop ? 1 : 0);
    if (m.ph == 0 && halt) begin
      n.ph = 1;
      n.exit_code = a0[31:1];
      n.status = (a7 != 32'h5d) ? 3 : ((a0 == 32'd0) ? 1 : 2);
    end else if (m.ph == 0 && tmo_hit) begin
      n.ph = 1;
      n.status = 4;
      n.exit_code = '0;
    end else if (m.ph == 1 && n.occ == 0) begin
      n.ph = 2;
    end
    return n;
  endfunction

  function automatic logic [127:0] pk(input logic v, input logic ov, input logic [15:0] dr,
                                      input logic [31:0] rt, input logic [31:0] cy,
                                      input logic [2:0] stt, input logic [30:0] ex, input logic dn);
    return {11'd0, v, ov, dr, rt, cy, stt, ex, dn};
  endfunction

  function automatic logic [127:0] pk_m(input mdl_t m);
    return pk(m.occ > 0, m.ovf, 16'(m.drop), m.ret, m.cyc, 3'(m.status), m.exit_code, m.ph == 2);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_regs(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL regs_%s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Advance one clock with the currently driven inputs, then check both instances.
  task automatic step();
    mdl_t na, nb;
    bit acc_a, acc_b;
    na = mstep(ma, MASK_A, TMO_A, acc_a);
    nb = mstep(mb, MASK_B, TMO_B, acc_b);
    if (acc_a) sb.push_back({pc, rd_wr, rd_addr, rd_data, mem_we, mem_sel, mem_addr, mem_data});
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    if (rst) sb.delete();
    cmp_regs("a", pk(a_valid, a_ovf, a_drop, a_ret, a_cyc, a_status, a_exit, a_done), pk_m(ma));
    cmp_regs("b", pk(b_valid, b_ovf, b_drop, b_ret, b_cyc, b_status, b_exit, b_done), pk_m(mb));
  endtask

  task automatic idle();
    rv = 1'b0; rd_wr = 1'b0; mem_we = 1'b0;
    ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    idle();
    ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic retire_rd(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
    idle();
    rv = 1'b1; pc = p; rd_wr = 1'b1; rd_addr = r; rd_data = d;
    mem_addr = $urandom; mem_data = $urandom; mem_sel = 4'($urandom);
    step();
  endtask

  task automatic halt_case(input string nm, input logic [31:0] va7, input logic [31:0] va0,
                           input logic [2:0] exp_st, input logic [30:0] exp_ex);
    do_reset();
    for (int i = 0; i < 3; i++) retire_rd(32'h100 + 32'(i * 4), 5'(i + 1), $urandom);
    idle();
    rv = 1'b1; ecall = 1'b1; a7 = va7; a0 = va0; pc = 32'h200;
    rd_wr = 1'b1; rd_addr = 5'd9; rd_data = $urandom;
    step();
    idle();
    a7 = $urandom; a0 = $urandom;
    rv = 1'b1; rd_wr = 1'b1; rd_addr = 5'd4; ecall = 1'b1;
    step();
    step();
    idle_steps(1);
    chk({nm, "_done_wait"}, 64'(a_done), 64'd0);
    chk({nm, "_status"}, 64'(a_status), 64'(exp_st));
    chk({nm, "_exit"}, 64'(a_exit), 64'(exp_ex));
    ready = 1'b1;
    idle_steps(8);
    chk({nm, "_done"}, 64'(a_done), 64'd1);
    chk({nm, "_retires"}, 64'(a_ret), 64'd4);
  endtask

  always @(negedge clk) begin
    if (!rst && a_valid === 1'b1 && ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL trace_pop: got record %h, expected none pending", a_data);
      end else begin
        exp_rec = sb.pop_front();
        if (a_data !== exp_rec) begin
          n_err++;
          $display("FAIL trace_rec: got %h, expected %h", a_data, exp_rec);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int pct;
    ma = '{default: 0};
    mb = '{default: 0};
    pc = '0; rd_addr = '0; rd_data = '0; mem_addr = '0; mem_data = '0; mem_sel = '0;
    a0 = '0; a7 = '0;
    do_reset();
    do_reset();
    chk("reset_valid", 64'(a_valid), 64'd0);

    // addi x5,x0,7 then sw, then rd=x0 and a branch
    ready = 1'b1;
    retire_rd(32'h0, 5'd5, 32'd7);
    chk("addi_count", 64'(a_ret), 64'd1);
    idle();
    rv = 1'b1; pc = 32'h4; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_addr = 32'h1004; mem_data = 32'hcafe_f00d; rd_addr = 5'd0;
    step();
    retire_rd(32'h8, 5'd0, 32'd99);
    idle(); rv = 1'b1; pc = 32'hc; rd_addr = 5'd12; step();
    idle_steps(3);
    chk("noqual_count", 64'(a_ret), 64'd4);
    chk("noqual_empty", 64'(a_valid), 64'd0);

    // overflow: 20 qualifying retires into a 16-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 20; i++) retire_rd(32'h400 + 32'(i * 4), 5'(i % 31 + 1), $urandom);
    chk("ovf_drop", 64'(a_drop), 64'd4);
    chk("ovf_flag", 64'(a_ovf), 64'd1);
    ready = 1'b1;
    retire_rd(32'h500, 5'd7, 32'h1234_5678);
    chk("full_push_pop_drop", 64'(a_drop), 64'd4);
    idle_steps(20);

    // randomized retire stream with varying consumer pressure
    do_reset();
    for (int seg = 0; seg < 5; seg++) begin
      pct = (seg == 0) ? 90 : (seg == 1) ? 10 : (seg == 2) ? 50 : (seg == 3) ? 0 : 100;
      for (int i = 0; i < 300; i++) begin
        idle();
        rv = ($urandom_range(0, 3) != 0);
        pc = $urandom & 32'hffff_fffc;
        rd_wr = $urandom_range(0, 1) == 1;
        rd_addr = 5'($urandom);
        rd_data = $urandom;
        mem_we = ($urandom_range(0, 3) == 0);
        mem_addr = $urandom; mem_data = $urandom; mem_sel = 4'($urandom);
        a0 = $urandom; a7 = $urandom;
        ready = ($urandom_range(0, 99) < pct);
        step();
      end
    end
    ready = 1'b1;
    idle_steps(25);
    chk("rand_sb_drained", 64'(sb.size()), 64'd0);

    halt_case("pass", 32'h5d, 32'd0, 3'd1, 31'd0);
    halt_case("fail", 32'h5d, 32'd6, 3'd2, 31'd3);
    halt_case("unknown", 32'd0, 32'd0, 3'd3, 31'd0);

    // ebreak: instance A halts, instance B (ecall-only) runs into its watchdog
    do_reset();
    ready = 1'b1;
    idle();
    rv = 1'b1; ebreak = 1'b1; a7 = 32'h5d; a0 = 32'd0;
    step();
    idle_steps(48);
    chk("ebreak_a_status", 64'(a_status), 64'd1);
    chk("ebreak_b_run", 64'(b_status), 64'd0);
    idle_steps(1);
    chk("tmo_status", 64'(b_status), 64'd4);
    chk("tmo_cycles", 64'(b_cyc), 64'd50);
    chk("tmo_exit", 64'(b_exit), 64'd0);
    idle_steps(1);
    chk("tmo_done", 64'(b_done), 64'd1);

    // reset while draining
    do_reset();
    for (int i = 0; i < 4; i++) retire_rd(32'h800 + 32'(i * 4), 5'(i + 2), $urandom);
    idle();
    rv = 1'b1; ecall = 1'b1; a7 = 32'h5d; a0 = 32'd2;
    step();
    idle_steps(2);
    chk("drain_status", 64'(a_status), 64'd2);
    do_reset();
    chk("mid_reset_status", 64'(a_status), 64'd0);
    chk("mid_reset_valid", 64'(a_valid), 64'd0);
    idle_steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
